// File: rtl/cache_refill_ctrl.sv
// Miss/refill sequencer with per-set 8-way tree pseudo-LRU; a hit retires in the same cycle, a miss retires one cycle after the last beat.
// Memory request waits on mem_rd_ready; refill beats may arrive with gaps. Optional hit/miss counters: REFILL_PERF_CNT_EN.
module cache_refill_ctrl #(
  parameter int SETS   = 64,
  parameter int IDX_W  = 6,
  parameter int BEATS  = 4,
  parameter int BEAT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [IDX_W-1:0]  cpu_idx,
  input  logic              hit,
  input  logic [2:0]        hit_way,
  output logic              cpu_done,
  output logic              busy,
  output logic              mem_rd_req,
  input  logic              mem_rd_ready,
  input  logic              mem_rvalid,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [2:0]        fill_way,
  output logic [BEAT_W-1:0] fill_beat,
  output logic              tag_we
`ifdef REFILL_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Replacement word layout: [0] root, [2:1] inner, [6:3] leaf.
  function automatic logic [2:0] plru_victim(input logic [6:0] s);
    logic [2:0] v;
    logic [1:0] inner;
    logic [3:0] leaf;
    inner = s[2:1];
    leaf  = s[6:3];
    v[2]  = s[0];
    v[1]  = inner[v[2]];
    v[0]  = leaf[{v[2], v[1]}];
    return v;
  endfunction

  function automatic logic [6:0] plru_touch(input logic [6:0] s, input logic [2:0] p);
    logic [1:0] inner;
    logic [3:0] leaf;
    inner           = s[2:1];
    leaf            = s[6:3];
    inner[p[2]]     = ~p[1];
    leaf[p[2:1]]    = ~p[0];
    return {leaf, inner, ~p[2]};
  endfunction

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [2:0]        way_q, way_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [6:0]        plru_q [SETS];

  logic              touch_en;
  logic [IDX_W-1:0]  touch_set;
  logic [2:0]        touch_way;
  logic              last_beat;

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign fill_idx  = idx_q;
  assign fill_way  = way_q;
  assign fill_beat = beat_q;
  assign busy      = (state_q != S_IDLE) && !rst;

  // Outputs are forced low while rst is high, even before the state register has been cleared.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    way_d      = way_q;
    beat_d     = beat_q;
    touch_en   = 1'b0;
    touch_set  = cpu_idx;
    touch_way  = hit_way;
    cpu_done   = 1'b0;
    mem_rd_req = 1'b0;
    fill_we    = 1'b0;
    tag_we     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            if (hit) begin
              cpu_done = 1'b1;
              touch_en = 1'b1;
            end else begin
              idx_d   = cpu_idx;
              way_d   = plru_victim(plru_q[cpu_idx]);
              beat_d  = '0;
              state_d = S_REQ;
            end
          end
        end
        S_REQ: begin
          mem_rd_req = 1'b1;
          if (mem_rd_ready) state_d = S_FILL;
        end
        S_FILL: begin
          if (mem_rvalid) begin
            fill_we = 1'b1;
            beat_d  = beat_q + BEAT_W'(1);
            if (last_beat) begin
              tag_we    = 1'b1;
              touch_en  = 1'b1;
              touch_set = idx_q;
              touch_way = way_q;
              state_d   = S_DONE;
            end
          end
        end
        default: begin
          cpu_done = 1'b1;
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      way_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) plru_q[i] <= '0;
    end else if (touch_en) begin
      plru_q[touch_set] <= plru_touch(plru_q[touch_set], touch_way);
    end
  end

`ifdef REFILL_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        hit_evt, miss_evt;

  assign hit_evt  = (state_q == S_IDLE) && touch_en;
  assign miss_evt = (state_q == S_IDLE) && (state_d == S_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboarded bench: drivers push expected refill beats, a negedge monitor pops and compares every fill_we.
module tb_cache_refill_ctrl;

  localparam int SETS = 64, IDX_W = 6, BEATS = 4, BEAT_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0;
  logic [IDX_W-1:0]  cpu_idx = '0;
  logic              hit = 1'b0;
  logic [2:0]        hit_way = '0;
  logic              cpu_done, busy, mem_rd_req;
  logic              mem_rd_ready = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic              fill_we, tag_we;
  logic [IDX_W-1:0]  fill_idx;
  logic [2:0]        fill_way;
  logic [BEAT_W-1:0] fill_beat;
`ifdef REFILL_PERF_CNT_EN
  logic [31:0]       hit_cnt, miss_cnt;
`endif

  cache_refill_ctrl #(.SETS(SETS), .IDX_W(IDX_W), .BEATS(BEATS), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_idx(cpu_idx), .hit(hit), .hit_way(hit_way),
    .cpu_done(cpu_done), .busy(busy), .mem_rd_req(mem_rd_req), .mem_rd_ready(mem_rd_ready),
    .mem_rvalid(mem_rvalid), .fill_we(fill_we), .fill_idx(fill_idx), .fill_way(fill_way),
    .fill_beat(fill_beat), .tag_we(tag_we)
`ifdef REFILL_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_hits = 0;
  int n_miss = 0;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [2:0]        way;
    logic [BEAT_W-1:0] beat;
    logic              tag;
  } fill_t;
  fill_t exp_q[$];

  // Reference tree pseudo-LRU: one root bit, two inner bits, four leaf bits per set.
  bit       m_root  [SETS];
  bit [1:0] m_inner [SETS];
  bit [3:0] m_leaf  [SETS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_victim(input int s);
    logic [2:0] v;
    v[2] = m_root[s];
    v[1] = m_inner[s][v[2]];
    v[0] = m_leaf[s][{v[2], v[1]}];
    return v;
  endfunction

  task automatic m_touch(input int s, input logic [2:0] p);
    m_root[s]                 = ~p[2];
    m_inner[s][p[2]]          = ~p[1];
    m_leaf[s][{p[2], p[1]}]   = ~p[0];
  endtask

  task automatic m_reset();
    for (int i = 0; i < SETS; i++) begin
      m_root[i] = 0; m_inner[i] = '0; m_leaf[i] = '0;
    end
    n_hits = 0;
    n_miss = 0;
    exp_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, decoupled from the drivers.
  always @(negedge clk) begin
    if (!rst) begin
      if (fill_we) begin
        if (exp_q.size() == 0) begin
          chk("fill_we_unexpected", fill_we, 0);
        end else begin
          fill_t e;
          e = exp_q.pop_front();
          chk("sb_fill_idx", fill_idx, e.idx);
          chk("sb_fill_way", fill_way, e.way);
          chk("sb_fill_beat", fill_beat, e.beat);
          chk("sb_tag_we", tag_we, e.tag);
        end
      end else if (tag_we) begin
        chk("tag_we_without_fill", tag_we, 0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; hit = 1'b0; mem_rd_ready = 1'b0; mem_rvalid = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_cpu_done", cpu_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd_req", mem_rd_req, 0);
    chk("rst_fill_we", fill_we, 0);
    chk("rst_tag_we", tag_we, 0);
    chk("rst_fill_idx", fill_idx, 0);
    chk("rst_fill_way", fill_way, 0);
    chk("rst_fill_beat", fill_beat, 0);
`ifdef REFILL_PERF_CNT_EN
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
`endif
    step();
    rst = 1'b0;
    m_reset();
  endtask

  task automatic do_hit(input int idx, input logic [2:0] way);
    cpu_req = 1'b1; hit = 1'b1; cpu_idx = IDX_W'(idx); hit_way = way;
    mem_rvalid = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("hit_same_cycle_done", cpu_done, 1);
    chk("hit_not_busy", busy, 0);
    step();
    cpu_req = 1'b0; hit = 1'b0; mem_rvalid = 1'b0;
    m_touch(idx, way);
    n_hits++;
  endtask

  // abort_after < 0: full refill; otherwise reset after that many beats. exp_way >= 0: directed victim check.
  task automatic do_miss(input int idx, input int rdy_dly, input int gap, input int abort_after, input int exp_way);
    logic [2:0] v;
    int nb, req_cycles;
    v  = m_victim(idx);
    nb = (abort_after < 0) ? BEATS : abort_after;
    for (int b = 0; b < nb; b++)
      exp_q.push_back('{idx: IDX_W'(idx), way: v, beat: BEAT_W'(b), tag: (b == BEATS - 1)});
    cpu_req = 1'b1; hit = 1'b0; cpu_idx = IDX_W'(idx);
    @(negedge clk);
    chk("miss_no_done", cpu_done, 0);
    step();
    req_cycles = 0;
    for (int i = 0; i <= rdy_dly; i++) begin
      mem_rd_ready = (i == rdy_dly);
      mem_rvalid   = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (mem_rd_req) req_cycles++;
      chk("busy_req", busy, 1);
      step();
    end
    mem_rd_ready = 1'b0;
    chk("rd_req_cycles", req_cycles, rdy_dly + 1);
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < gap; g++) begin
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("busy_gap", busy, 1);
        step();
      end
      mem_rvalid = 1'b1;
      @(negedge clk);
      chk("busy_beat", busy, 1);
      step();
    end
    mem_rvalid = 1'b0;
    if (abort_after >= 0) begin
      rst = 1'b1; cpu_req = 1'b0;
      step();
      rst = 1'b0;
      m_reset();
    end else begin
      @(negedge clk);
      chk("done_after_last_beat", cpu_done, 1);
      chk("fill_idx_hold", fill_idx, idx);
      if (exp_way >= 0) chk("victim_way", fill_way, exp_way);
      cpu_req = 1'b0;
      m_touch(idx, v);
      n_miss++;
      step();
      @(negedge clk);
      chk("done_one_cycle", cpu_done, 0);
      chk("idle_not_busy", busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[8];
    seq = '{0, 4, 2, 6, 1, 5, 3, 7};
    m_reset();

    do_reset();
    for (int i = 0; i < 8; i++) do_miss(5, 0, 0, -1, seq[i]);

    do_reset();
    do_miss(5, 0, 0, -1, 0);
    do_hit(5, 3'd4);
    do_miss(5, 0, 0, -1, 2);

    do_miss(7, 3, 2, -1, -1);

    do_reset();
    do_miss(3, 1, 0, -1, 0);
    do_miss(9, 0, 1, -1, 0);
    do_miss(3, 0, 0, -1, 4);

    do_reset();
    do_miss(6, 1, 1, 2, -1);
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      @(negedge clk);
      chk("stray_fill_we", fill_we, 0);
      chk("stray_tag_we", tag_we, 0);
      step();
    end
    mem_rvalid = 1'b0;
    do_miss(6, 0, 0, -1, 0);

    do_reset();
    do_hit(1, 3'd2);
    do_miss(1, 0, 0, -1, -1);
    do_hit(1, 3'd5);
    do_miss(2, 2, 1, -1, -1);
    do_hit(2, 3'd7);
`ifdef REFILL_PERF_CNT_EN
    @(negedge clk);
    chk("hit_cnt", hit_cnt, n_hits);
    chk("miss_cnt", miss_cnt, n_miss);
    step();
`endif

    for (int it = 0; it < 80; it++) begin
      int idx;
      idx = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0)
        do_miss(idx, $urandom_range(0, 3), $urandom_range(0, 2), -1, -1);
      else
        do_hit(idx, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) step();
    end
`ifdef REFILL_PERF_CNT_EN
    @(negedge clk);
    chk("hit_cnt_rand", hit_cnt, n_hits);
    chk("miss_cnt_rand", miss_cnt, n_miss);
`endif

    do_reset();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
